// File: rtl/calc_controller.sv
// Sequencing FSM for a 4-digit BCD calculator: builds operands from keypad strobes, drives the
// add/subtract ALU, and latches its result for display. Optional: CALC_NEG_DETECT_EN.
module calc_controller #(
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] alu_result,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        op_selected,
  output logic [15:0] disp,
  output logic        busy,
  output logic        neg,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StEnterA  = 2'd0,
    StEnterB  = 2'd1,
    StCompute = 2'd2,
    StShow    = 2'd3
  } state_e;

  localparam logic [2:0] MaxCnt = 3'(MAX_DIGITS);

  state_e      state_q, state_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] disp_q, disp_d;
  logic        op_sel_q, op_sel_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        cmp_q, cmp_d;

  logic        is_digit, is_add_sub, is_eq, is_ce;
  logic [15:0] cur_op, shifted;
  logic        accept;

  assign is_digit   = key_valid && (key_code < 4'd10);
  assign is_add_sub = key_valid && (key_code == 4'd10 || key_code == 4'd11);
  assign is_eq      = key_valid && (key_code == 4'd12);
  assign is_ce      = key_valid && (key_code == 4'd13);

  // Shared digit-entry datapath for whichever operand is being typed
  assign cur_op  = (state_q == StEnterB) ? op_b_q : op_a_q;
  assign shifted = {cur_op[11:0], key_code};
  assign accept  = (cnt_q != MaxCnt) && !(cur_op == 16'h0000 && key_code == 4'd0);

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    disp_d   = disp_q;
    op_sel_d = op_sel_q;
    cnt_d    = cnt_q;
    cmp_d    = cmp_q;
    unique case (state_q)
      StEnterA: begin
        if (is_digit) begin
          if (accept) begin
            op_a_d = shifted;
            cnt_d  = cnt_q + 3'd1;
            disp_d = shifted;
          end
        end else if (is_add_sub) begin
          op_sel_d = key_code[0];
          op_b_d   = 16'h0000;
          cnt_d    = 3'd0;
          state_d  = StEnterB;
        end else if (is_ce) begin
          op_a_d = 16'h0000;
          cnt_d  = 3'd0;
          disp_d = 16'h0000;
        end
      end
      StEnterB: begin
        if (is_digit) begin
          if (accept) begin
            op_b_d = shifted;
            cnt_d  = cnt_q + 3'd1;
            disp_d = shifted;
          end
        end else if (is_add_sub) begin
          // Operator may be changed only before any B digit has been entered
          if (cnt_q == 3'd0 && op_b_q == 16'h0000) op_sel_d = key_code[0];
        end else if (is_eq) begin
          cmp_d   = 1'b0;
          state_d = StCompute;
        end else if (is_ce) begin
          op_b_d = 16'h0000;
          cnt_d  = 3'd0;
          disp_d = 16'h0000;
        end
      end
      StCompute: begin
        if (!cmp_q) begin
          cmp_d = 1'b1;
        end else begin
          disp_d  = alu_result;
          state_d = StShow;
        end
      end
      StShow: begin
        if (is_digit) begin
          op_a_d  = {12'h000, key_code};
          cnt_d   = {2'b00, key_code != 4'd0};
          op_b_d  = 16'h0000;
          disp_d  = {12'h000, key_code};
          state_d = StEnterA;
        end else if (is_add_sub) begin
          op_a_d   = disp_q;
          op_b_d   = 16'h0000;
          cnt_d    = 3'd0;
          op_sel_d = key_code[0];
          state_d  = StEnterB;
        end else if (is_eq) begin
          op_a_d  = disp_q;
          cmp_d   = 1'b0;
          state_d = StCompute;
        end else if (is_ce) begin
          op_a_d   = 16'h0000;
          op_b_d   = 16'h0000;
          disp_d   = 16'h0000;
          op_sel_d = 1'b0;
          cnt_d    = 3'd0;
          state_d  = StEnterA;
        end
      end
      default: state_d = StEnterA;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= StEnterA;
      op_a_q   <= 16'h0000;
      op_b_q   <= 16'h0000;
      disp_q   <= 16'h0000;
      op_sel_q <= 1'b0;
      cnt_q    <= 3'd0;
      cmp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      disp_q   <= disp_d;
      op_sel_q <= op_sel_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
    end
  end

`ifdef CALC_NEG_DETECT_EN
  logic swap_q, swap_d;
  logic neg_q, neg_d;
  logic enter_compute, capture, enter_a;

  assign enter_compute = (state_q != StCompute) && (state_d == StCompute);
  assign capture       = (state_q == StCompute) && (state_d == StShow);
  assign enter_a       = (state_q != StEnterA) && (state_d == StEnterA);

  // Swap decision uses the operands as they will be held during COMPUTE
  always_comb begin
    swap_d = swap_q;
    neg_d  = neg_q;
    if (enter_compute) swap_d = op_sel_d && (op_a_d < op_b_d);
    if (capture) begin
      neg_d  = swap_q;
      swap_d = 1'b0;
    end
    if (enter_a) neg_d = 1'b0;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      swap_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      swap_q <= swap_d;
      neg_q  <= neg_d;
    end
  end

  assign alu_a = swap_q ? op_b_q : op_a_q;
  assign alu_b = swap_q ? op_a_q : op_b_q;
  assign neg   = neg_q;
`else
  assign alu_a = op_a_q;
  assign alu_b = op_b_q;
  assign neg   = 1'b0;
`endif

  assign op_selected = op_sel_q;
  assign disp        = disp_q;
  assign busy        = (state_q == StCompute);
  assign state       = state_q;

endmodule

// File: tb/tb_calc_controller.sv
// Directed self-checking bench for calc_controller, with a registered BCD ALU model in the loop.
module tb_calc_controller;

  localparam logic [3:0] KAdd = 4'd10;
  localparam logic [3:0] KSub = 4'd11;
  localparam logic [3:0] KEq  = 4'd12;
  localparam logic [3:0] KCe  = 4'd13;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [15:0] alu_result;
  logic [15:0] alu_a, alu_b, disp;
  logic        op_selected, busy, neg;
  logic [1:0]  state;

  logic [15:0] alu_a2, alu_b2, disp2;
  logic        op_selected2, busy2, neg2;
  logic [1:0]  state2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calc_controller u_dut (
    .clk        (clk),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_result (alu_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .op_selected(op_selected),
    .disp       (disp),
    .busy       (busy),
    .neg        (neg),
    .state      (state)
  );

  calc_controller #(.MAX_DIGITS(2)) u_dut2 (
    .clk        (clk),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_result (16'h0000),
    .alu_a      (alu_a2),
    .alu_b      (alu_b2),
    .op_selected(op_selected2),
    .disp       (disp2),
    .busy       (busy2),
    .neg        (neg2),
    .state      (state2)
  );

  function automatic int bcd2int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int x);
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // One-cycle registered BCD adder/subtractor with 10000-complement wrap
  always_ff @(posedge clk) begin
    if (op_selected)
      alu_result <= int2bcd((bcd2int(alu_a) - bcd2int(alu_b) + 10000) % 10000);
    else
      alu_result <= int2bcd((bcd2int(alu_a) + bcd2int(alu_b)) % 10000);
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear = 1'b1;
    #1;
    n_checks++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL reset_disp: got %h expected 0000", disp); end
    n_checks++; if (alu_a !== 16'h0000) begin n_fail++; $display("FAIL reset_alu_a: got %h expected 0000", alu_a); end
    n_checks++; if (alu_b !== 16'h0000) begin n_fail++; $display("FAIL reset_alu_b: got %h expected 0000", alu_b); end
    n_checks++; if (op_selected !== 1'b0) begin n_fail++; $display("FAIL reset_op: got %b expected 0", op_selected); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg: got %b expected 0", neg); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_add();
    int cyc;
    do_reset();
    press(4'd1); press(4'd2); press(4'd3);
    n_checks++; if (disp !== 16'h0123) begin n_fail++; $display("FAIL add_entry_a: got %h expected 0123", disp); end
    press(KAdd);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL add_state_b: got %0d expected 1", state); end
    press(4'd4); press(4'd5);
    n_checks++; if (disp !== 16'h0045) begin n_fail++; $display("FAIL add_entry_b: got %h expected 0045", disp); end
    press(KEq);
    n_checks++; if (alu_a !== 16'h0123 || alu_b !== 16'h0045) begin n_fail++; $display("FAIL add_alu_ops: got %h/%h expected 0123/0045", alu_a, alu_b); end
    wait_done(cyc);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL add_busy_cycles: got %0d expected 2", cyc); end
    n_checks++; if (disp !== 16'h0168) begin n_fail++; $display("FAIL add_result: got %h expected 0168", disp); end
    n_checks++; if (op_selected !== 1'b0) begin n_fail++; $display("FAIL add_op: got %b expected 0", op_selected); end
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL add_state_show: got %0d expected 3", state); end
  endtask

  task automatic test_sub_underflow();
    int cyc;
    do_reset();
    press(4'd7); press(KSub); press(4'd5); press(4'd0); press(KEq);
`ifdef CALC_NEG_DETECT_EN
    n_checks++; if (alu_a !== 16'h0050 || alu_b !== 16'h0007) begin n_fail++; $display("FAIL sub_alu_swap: got %h/%h expected 0050/0007", alu_a, alu_b); end
    wait_done(cyc);
    n_checks++; if (disp !== 16'h0043) begin n_fail++; $display("FAIL sub_result: got %h expected 0043", disp); end
    n_checks++; if (neg !== 1'b1) begin n_fail++; $display("FAIL sub_neg: got %b expected 1", neg); end
`else
    n_checks++; if (alu_a !== 16'h0007 || alu_b !== 16'h0050) begin n_fail++; $display("FAIL sub_alu_ops: got %h/%h expected 0007/0050", alu_a, alu_b); end
    wait_done(cyc);
    n_checks++; if (disp !== 16'h9957) begin n_fail++; $display("FAIL sub_result: got %h expected 9957", disp); end
    n_checks++; if (neg !== 1'b0) begin n_fail++; $display("FAIL sub_neg: got %b expected 0", neg); end
`endif
    n_checks++; if (op_selected !== 1'b1) begin n_fail++; $display("FAIL sub_op: got %b expected 1", op_selected); end
  endtask

  task automatic test_digit_limit();
    do_reset();
    press(4'd0); press(4'd0);
    n_checks++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL limit_lead_zero: got %h expected 0000", disp); end
    press(4'd5);
    n_checks++; if (disp !== 16'h0005) begin n_fail++; $display("FAIL limit_first: got %h expected 0005", disp); end
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    n_checks++; if (disp !== 16'h5999) begin n_fail++; $display("FAIL limit_max4: got %h expected 5999", disp); end
    do_reset();
    press(4'd1); press(4'd2); press(4'd3);
    n_checks++; if (disp2 !== 16'h0012) begin n_fail++; $display("FAIL limit_max2: got %h expected 0012", disp2); end
    n_checks++; if (disp !== 16'h0123) begin n_fail++; $display("FAIL limit_max4_short: got %h expected 0123", disp); end
    press(KCe);
    n_checks++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL ce_clear: got %h expected 0000", disp); end
    press(4'd6); press(4'd7); press(4'd8); press(4'd9); press(4'd1);
    n_checks++; if (disp !== 16'h6789) begin n_fail++; $display("FAIL ce_count_reset: got %h expected 6789", disp); end
  endtask

  task automatic test_chaining();
    int cyc;
    do_reset();
    press(4'd2); press(KAdd); press(4'd3); press(KEq);
    wait_done(cyc);
    n_checks++; if (disp !== 16'h0005) begin n_fail++; $display("FAIL chain_first: got %h expected 0005", disp); end
    press(KAdd); press(4'd4); press(KEq);
    wait_done(cyc);
    n_checks++; if (disp !== 16'h0009) begin n_fail++; $display("FAIL chain_second: got %h expected 0009", disp); end
    press(KEq);
    n_checks++; if (alu_a !== 16'h0009 || alu_b !== 16'h0004) begin n_fail++; $display("FAIL chain_repeat_ops: got %h/%h expected 0009/0004", alu_a, alu_b); end
    wait_done(cyc);
    n_checks++; if (disp !== 16'h0013) begin n_fail++; $display("FAIL chain_repeat: got %h expected 0013", disp); end
    press(4'd6);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL chain_digit_state: got %0d expected 0", state); end
    n_checks++; if (disp !== 16'h0006) begin n_fail++; $display("FAIL chain_digit_disp: got %h expected 0006", disp); end
  endtask

  task automatic test_op_replace();
    int cyc;
    do_reset();
    press(4'd8); press(KAdd); press(KSub);
    n_checks++; if (op_selected !== 1'b1) begin n_fail++; $display("FAIL replace_op: got %b expected 1", op_selected); end
    press(4'd3); press(KSub);
    n_checks++; if (op_selected !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL replace_late_op: got %b/%0d expected 1/1", op_selected, state); end
    press(KEq);
    // Digit arriving on the first COMPUTE edge must be dropped
    key_valid = 1'b1;
    key_code  = 4'd9;
    @(negedge clk);
    key_valid = 1'b0;
    wait_done(cyc);
    n_checks++; if (disp !== 16'h0005) begin n_fail++; $display("FAIL replace_result: got %h expected 0005", disp); end
    @(negedge clk);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL drop_in_compute: got state %0d expected 3", state); end
  endtask

  task automatic test_clear_mid_compute();
    do_reset();
    press(4'd1); press(KAdd); press(4'd2); press(KEq);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy_before: got %b expected 1", busy); end
    clear = 1'b1;
    #1;
    n_checks++; if (disp !== 16'h0000 || busy !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL midclr_immediate: got %h/%b/%0d expected 0000/0/0", disp, busy, state); end
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (disp !== 16'h0000 || state !== 2'd0) begin n_fail++; $display("FAIL midclr_no_capture: got %h/%0d expected 0000/0", disp, state); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_underflow();
    test_digit_limit();
    test_chaining();
    test_op_replace();
    test_clear_mid_compute();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Sequencing FSM for the 4-digit BCD calculator.
- Takes decoded keypad strobes and builds operand A and operand B digit by digit, left-shift entry.
- Drives the BCD add/subtract ALU (operands plus op_selected), waits out its registered latency, and latches the result for the display.
- Supports result chaining and repeated '='.

Parameters:
- MAX_DIGITS, 4, maximum significant digits accepted per operand (1..4); further digit keys are dropped.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid when high.
- key_code  in  4  0-9 digit, 10 add, 11 subtract, 12 equals, 13 CE, 14-15 ignored.
- alu_result  in  16  ALU result, packed {thousands,hundreds,tens,ones}.
- alu_a  out  16  operand A to ALU, packed BCD.
- alu_b  out  16  operand B to ALU, packed BCD.
- op_selected  out  1  0 = add, 1 = subtract.
- disp  out  16  packed BCD value for the display.
- busy  out  1  high while in COMPUTE.
- neg  out  1  result-negative flag (see Optional Feature).
- state  out  2  ENTER_A=0, ENTER_B=1, COMPUTE=2, SHOW=3.

Behaviour:
- Reset (clear high, asynchronous):
  - op_a, op_b, alu_a, alu_b, disp = 0x0000.
  - op_selected = 0, busy = 0, neg = 0, digit count = 0, state = ENTER_A.
  - Reset mid-COMPUTE aborts immediately; no capture occurs.
- All key handling is on the rising edge with key_valid=1. Keys arriving while in COMPUTE are dropped, not queued.
- Digit entry (ENTER_A into op_a, ENTER_B into op_b):
  - operand <= {operand[11:0], d}; count increments.
  - Leading zero (operand==0, d==0): operand unchanged, count unchanged.
  - count==MAX_DIGITS: digit dropped.
- ENTER_A:
  - Digit: as above. disp follows op_a the same cycle it is updated.
  - Add/sub: set op_selected; op_b<=0; count<=0; go to ENTER_B.
  - '=': ignored.
  - CE: op_a<=0, count<=0.
- ENTER_B:
  - Digit: as above. disp follows op_b.
  - Add/sub with count==0 and op_b==0: replaces op_selected.
  - Add/sub otherwise: ignored.
  - '=': go to COMPUTE.
  - CE: op_b<=0, count<=0.
- COMPUTE (exactly 2 cycles, busy=1):
  - alu_a/alu_b are held stable throughout.
  - '=' sampled at edge n; the ALU captures at edge n+1; at edge n+2 disp<=alu_result and state<=SHOW with busy=0.
  - alu_a/alu_b equal op_a/op_b continuously, except under the Optional Feature swap.
- SHOW:
  - Digit: op_a<={12'h000,d} (count 1, or 0 if d==0); op_b<=0; go to ENTER_A.
  - Add/sub: op_a<=disp; op_b<=0; count<=0; set op_selected; go to ENTER_B.
  - '=': op_a<=disp; op_b and op_selected kept; go to COMPUTE (repeat operation).
  - CE: full clear, equivalent to reset values, state ENTER_A.
- Arithmetic:
  - Operands are always valid BCD (digits 0-9); the controller never forms non-BCD digits.
  - Packed BCD magnitude comparison equals binary comparison of the 16-bit words.
- neg is cleared on any transition into ENTER_A.

Optional Feature:
- Macro: CALC_NEG_DETECT_EN.
- Defined:
  - On the '=' edge with op_selected=1 and op_a<op_b, COMPUTE drives alu_a=op_b and alu_b=op_a.
  - neg is set at capture, so disp shows the magnitude.
  - When chaining from SHOW, op_a<=disp takes the magnitude only; neg is cleared on the next COMPUTE capture unless a swap occurs again.
- Not defined: no swap; neg is tied 0; subtract underflow shows the ALU's 10000-complement wrap.

Test Plan:
- Keys 1,2,3,+,4,5,= -> disp 0x0168, op_selected 0; busy high exactly 2 cycles; state SHOW.
- Keys 7,-,5,0,= -> without macro disp 0x9957, neg 0; with CALC_NEG_DETECT_EN disp 0x0043, neg 1.
- Keys 0,0,5 then 9,9,9,9 -> op_a 0x0005 then 0x5999 (fourth 9 dropped); with MAX_DIGITS=2, keys 1,2,3 -> op_a 0x0012.
- Keys 2,+,3,= -> disp 0x0005; then +,4,= -> 0x0009; then = -> 0x0013; then digit 6 -> state ENTER_A, disp 0x0006.
- Keys 8,+,-,3,= -> op_selected 1, disp 0x0005; a digit key during COMPUTE is dropped; result unchanged.
- Assert clear one cycle after '=' (mid-COMPUTE) -> disp 0x0000, busy 0, state ENTER_A immediately; alu_result ignored.
